pc_gen: RTL and testbench

Parametrised fetch-address generator for the NPC front end. It produces sequential instruction addresses from a configurable reset vector and buffers up to DEPTH of them in a small prefetch queue. The queue feeds the IFU through a valid/ready handshake. A redirect from EXU/WBU flushes the queue, restarts generation at the target address and toggles an epoch bit so the downstream stages can drop stale fetches.

---
 rtl/pc_gen_if.sv | 42 ++++
 rtl/pc_gen.sv | 116 +++++++++++
 tb/tb_pc_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-address bus between pc_gen and its consumer (IFU + redirect sources).
// Latency: none, this is only a bundle of wires.
// Backpressure: o_valid/i_ready handshake on the head, redirect is unconditional.
interface pc_gen_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             i_redirect_valid;
    logic [XLEN-1:0]  i_redirect_pc;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_pc;
    logic             o_epoch;
    logic [CNT_W-1:0] o_count;
    logic             o_misalign;

    // Generator side: receives redirects and the ready, drives the queue head.
    modport master (
        input  i_redirect_valid,
        input  i_redirect_pc,
        input  i_ready,
        output o_valid,
        output o_pc,
        output o_epoch,
        output o_count,
        output o_misalign
    );

    // Consumer side: IFU plus whoever raises redirects.
    modport slave (
        output i_redirect_valid,
        output i_redirect_pc,
        output i_ready,
        input  o_valid,
        input  o_pc,
        input  o_epoch,
        input  o_count,
        input  o_misalign
    );
endinterface

// File: rtl/pc_gen.sv
// Sequential fetch-address generator feeding a DEPTH-entry prefetch queue; redirects flush and toggle epoch.
// Latency: first head 1 cycle after reset release, redirect target valid 2 cycles after the request.
// Backpressure: i_ready low stalls the head; queue fills then next_pc holds. Optional macro PC_GEN_MISALIGN_CHECK_EN.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
    parameter int              STEP         = 4,
    parameter int              DEPTH        = 4
) (
    input  logic     i_clock,
    input  logic     reset,
    pc_gen_if.master fetch_if
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  next_pc_q, next_pc_d;
    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             epoch_q, epoch_d;

    logic             pop;
    logic             push;
    logic [XLEN-1:0]  target_pc;

    // A redirect voids any handshake in its cycle, so pop/push both yield to it.
    assign pop  = (count_q != '0) && fetch_if.i_ready && !fetch_if.i_redirect_valid;
    // Popping frees a slot on the same edge, so a full queue with a pop still accepts a new address.
    assign push = !fetch_if.i_redirect_valid &&
                  ((count_q < CNT_W'(DEPTH)) || ((count_q != '0) && fetch_if.i_ready));

`ifdef PC_GEN_MISALIGN_CHECK_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = (STEP == 2) ? XLEN'(1) : XLEN'(3);

    logic target_mis;
    logic misalign_q, misalign_d;

    // Clear the low bits that STEP-aligned fetches can never have and remember that we did.
    always_comb begin
        target_pc  = fetch_if.i_redirect_pc & ~ALIGN_MASK;
        target_mis = |(fetch_if.i_redirect_pc & ALIGN_MASK);
        misalign_d = fetch_if.i_redirect_valid && target_mis;
    end

    // Misalign flag lives for exactly the cycle after the offending redirect.
    always_ff @(posedge i_clock) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_if.o_misalign = misalign_q;
`else
    assign target_pc           = fetch_if.i_redirect_pc;
    assign fetch_if.o_misalign = 1'b0;
`endif

    // Next-state for pointers, occupancy, next_pc and epoch; redirect wins over push/pop.
    always_comb begin
        next_pc_d = next_pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        epoch_d   = epoch_q;

        if (fetch_if.i_redirect_valid) begin
            next_pc_d = target_pc;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            epoch_d   = ~epoch_q;
        end else begin
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                next_pc_d = next_pc_q + XLEN'(STEP);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        end
    end

    // Control state register; reset overrides redirect, push and pop on the same edge.
    always_ff @(posedge i_clock) begin
        if (reset) begin
            next_pc_q <= RESET_VECTOR;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            epoch_q   <= 1'b0;
        end else begin
            next_pc_q <= next_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            epoch_q   <= epoch_d;
        end
    end

    // Queue storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge i_clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= next_pc_q;
        end
    end

    assign fetch_if.o_valid = (count_q != '0);
    assign fetch_if.o_pc    = mem_q[rd_ptr_q];
    assign fetch_if.o_epoch = epoch_q;
    assign fetch_if.o_count = count_q;
endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h8000_0000;
`ifdef PC_GEN_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32), .DEPTH(DEPTH)) m_if ();
    pc_gen_if #(.XLEN(32), .DEPTH(DEPTH)) w_if ();

    pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .STEP(4), .DEPTH(DEPTH)) u_dut (
        .i_clock (clk),
        .reset   (rst),
        .fetch_if(m_if)
    );

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8), .STEP(4), .DEPTH(DEPTH)) u_wrap (
        .i_clock (clk),
        .reset   (rst),
        .fetch_if(w_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the queue is literally a queue of addresses.
    logic [31:0] mq [$];
    logic [31:0] m_next;
    logic        m_epoch;
    logic        m_mis;

    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        rst                   = r;
        m_if.i_redirect_valid = rv;
        m_if.i_redirect_pc    = rpc;
        m_if.i_ready          = rdy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_next  = RV;
            m_epoch = 1'b0;
            m_mis   = 1'b0;
        end else if (rv) begin
            mq.delete();
            m_next  = MIS_EN ? (rpc & ~32'h3) : rpc;
            m_mis   = MIS_EN && (rpc[1:0] != 2'b00);
            m_epoch = ~m_epoch;
        end else begin
            m_mis = 1'b0;
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                mq.push_back(m_next);
                m_next = m_next + 32'd4;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        checks++; if (m_if.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_if.o_valid); end
        checks++; if (m_if.o_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", m_if.o_count); end
        checks++; if (m_if.o_epoch !== 1'b0) begin errors++; $display("FAIL reset_epoch: got %b expected 0", m_if.o_epoch); end
        checks++; if (m_if.o_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", m_if.o_misalign); end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++; if (m_if.o_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", k, m_if.o_valid); end
            checks++; if (m_if.o_pc !== RV + 32'(4 * k)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", k, m_if.o_pc, RV + 32'(4 * k)); end
        end
    endtask

    task automatic test_fill();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            checks++; if (m_if.o_count !== 3'((k < 3) ? k + 1 : 4)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", k, m_if.o_count, (k < 3) ? k + 1 : 4); end
            checks++; if (m_if.o_pc !== RV) begin errors++; $display("FAIL fill_pc[%0d]: got %h expected %h", k, m_if.o_pc, RV); end
        end
        for (int k = 0; k < 5; k++) begin
            checks++; if (m_if.o_valid !== 1'b1 || m_if.o_pc !== RV + 32'(4 * k)) begin errors++; $display("FAIL drain_head[%0d]: got %b/%h expected 1/%h", k, m_if.o_valid, m_if.o_pc, RV + 32'(4 * k)); end
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
    endtask

    task automatic test_redirect();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (m_if.o_count !== 3'd3) begin errors++; $display("FAIL redir_pre_count: got %0d expected 3", m_if.o_count); end
        step(1'b0, 1'b1, 32'h8000_0100, 1'b1);
        checks++; if (m_if.o_valid !== 1'b0 || m_if.o_count !== 3'd0) begin errors++; $display("FAIL redir_flush: got %b/%0d expected 0/0", m_if.o_valid, m_if.o_count); end
        checks++; if (m_if.o_epoch !== 1'b1) begin errors++; $display("FAIL redir_epoch: got %b expected 1", m_if.o_epoch); end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++; if (m_if.o_valid !== 1'b1 || m_if.o_pc !== 32'h8000_0100 + 32'(4 * k)) begin errors++; $display("FAIL redir_head[%0d]: got %b/%h expected 1/%h", k, m_if.o_valid, m_if.o_pc, 32'h8000_0100 + 32'(4 * k)); end
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        checks++; if (m_if.o_epoch !== 1'b1) begin errors++; $display("FAIL b2b_epoch1: got %b expected 1", m_if.o_epoch); end
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        checks++; if (m_if.o_epoch !== 1'b0 || m_if.o_valid !== 1'b0) begin errors++; $display("FAIL b2b_epoch2: got %b/%b expected 0/0", m_if.o_epoch, m_if.o_valid); end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (m_if.o_valid !== 1'b1 || m_if.o_pc !== 32'h0000_0200) begin errors++; $display("FAIL b2b_head: got %b/%h expected 1/00000200", m_if.o_valid, m_if.o_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hFFFF_FFF8;
        exp_w[1] = 32'hFFFF_FFFC;
        exp_w[2] = 32'h0000_0000;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++; if (w_if.o_valid !== 1'b1 || w_if.o_pc !== exp_w[k]) begin errors++; $display("FAIL wrap_head[%0d]: got %b/%h expected 1/%h", k, w_if.o_valid, w_if.o_pc, exp_w[k]); end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_head;
        exp_head = MIS_EN ? 32'h8000_0100 : 32'h8000_0102;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h8000_0102, 1'b1);
        checks++; if (m_if.o_misalign !== MIS_EN) begin errors++; $display("FAIL mis_flag: got %b expected %b", m_if.o_misalign, MIS_EN); end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (m_if.o_misalign !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", m_if.o_misalign); end
        checks++; if (m_if.o_valid !== 1'b1 || m_if.o_pc !== exp_head) begin errors++; $display("FAIL mis_head: got %b/%h expected 1/%h", m_if.o_valid, m_if.o_pc, exp_head); end
    endtask

    task automatic test_random();
        logic        r, rv, rdy;
        logic [31:0] rpc;
        for (int k = 0; k < 600; k++) begin
            r   = ($urandom_range(0, 59) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rpc = $urandom;
            step(r, rv, rpc, rdy);
            checks++; if (m_if.o_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", k, m_if.o_valid, mq.size() != 0); end
            checks++; if (m_if.o_count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", k, m_if.o_count, mq.size()); end
            checks++; if (m_if.o_epoch !== m_epoch) begin errors++; $display("FAIL rnd_epoch[%0d]: got %b expected %b", k, m_if.o_epoch, m_epoch); end
            checks++; if (m_if.o_misalign !== m_mis) begin errors++; $display("FAIL rnd_misalign[%0d]: got %b expected %b", k, m_if.o_misalign, m_mis); end
            if (mq.size() != 0) begin
                checks++; if (m_if.o_pc !== mq[0]) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", k, m_if.o_pc, mq[0]); end
            end
        end
    endtask

    initial begin
        rst                   = 1'b1;
        m_if.i_redirect_valid = 1'b0;
        m_if.i_redirect_pc    = 32'h0;
        m_if.i_ready          = 1'b0;
        w_if.i_redirect_valid = 1'b0;
        w_if.i_redirect_pc    = 32'h0;
        w_if.i_ready          = 1'b1;
        m_next  = RV;
        m_epoch = 1'b0;
        m_mis   = 1'b0;

        test_reset();
        test_sequential();
        test_fill();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_misalign();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
